// File: rtl/magic_memory_lat.sv
// Dual-port word memory with per-port response latency and sticky error flags.
// Ports: A read-only (read_a/address_a -> resp_a/rdata_a), B read/write
// (read_b/write/wmask/address_b/wdata -> resp_b/rdata_b), err_conflict, err_range.
module magic_memory_lat #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LAT_A      = 1,
  parameter int LAT_B      = 2,
  parameter     INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read_a,
  input  logic [ADDR_WIDTH-1:0]   address_a,
  output logic                    resp_a,
  output logic [DATA_WIDTH-1:0]   rdata_a,
  input  logic                    read_b,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]   address_b,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    resp_b,
  output logic [DATA_WIDTH-1:0]   rdata_b,
  output logic                    err_conflict,
  output logic                    err_range
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int IW   = ADDR_WIDTH - 2;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LMAX = (LAT_A > LAT_B) ? LAT_A : LAT_B;
  localparam int CW   = $clog2(LMAX + 1);
  localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                sa, sa_n, sb, sb_n;
  logic [CW-1:0]         cnt_a, cnt_a_n, cnt_b, cnt_b_n;
  logic                  take_a, done_a, take_b, done_b, conflict;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q;
  logic                  ok_a_q, ok_b_q, we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         wmask_q;

  // Fields as seen at the edge entering RESP: live inputs when the access
  // is accepted and completed on the same edge, latched copies otherwise.
  logic                  in_a, in_b;
  logic                  ok_a_live, ok_b_live;
  logic                  eff_ok_a, eff_ok_b, eff_we;
  logic [AW-1:0]         eff_idx_a, eff_idx_b;
  logic [DATA_WIDTH-1:0] eff_wdata;
  logic [NB-1:0]         eff_wmask;

  logic unused_bits;
  assign unused_bits = ^{address_a[1:0], address_b[1:0],
                         addr_a_q[1:0], addr_b_q[1:0]};

  assign ok_a_live = {1'b0, address_a[ADDR_WIDTH-1:2]} < DEPTH_W;
  assign ok_b_live = {1'b0, address_b[ADDR_WIDTH-1:2]} < DEPTH_W;

  assign in_a      = (sa == IDLE);
  assign in_b      = (sb == IDLE);
  assign eff_ok_a  = in_a ? ok_a_live : ok_a_q;
  assign eff_ok_b  = in_b ? ok_b_live : ok_b_q;
  assign eff_idx_a = in_a ? address_a[AW+1:2] : addr_a_q[AW+1:2];
  assign eff_idx_b = in_b ? address_b[AW+1:2] : addr_b_q[AW+1:2];
  assign eff_we    = in_b ? write : we_q;
  assign eff_wdata = in_b ? wdata : wdata_q;
  assign eff_wmask = in_b ? wmask : wmask_q;

  assign resp_a = (sa == RESP);
  assign resp_b = (sb == RESP);

  always_comb begin
    sa_n    = sa;
    cnt_a_n = cnt_a;
    take_a  = 1'b0;
    done_a  = 1'b0;
    unique case (sa)
      IDLE: begin
        if (read_a) begin
          take_a = 1'b1;
          if (LAT_A <= 1) begin
            sa_n   = RESP;
            done_a = 1'b1;
          end else begin
            sa_n    = WAIT;
            cnt_a_n = CW'(LAT_A - 1);
          end
        end
      end
      WAIT: begin
        cnt_a_n = cnt_a - 1'b1;
        if (cnt_a == CW'(1)) begin
          sa_n   = RESP;
          done_a = 1'b1;
        end
      end
      RESP:    sa_n = IDLE;
      default: sa_n = IDLE;
    endcase
  end

  always_comb begin
    sb_n     = sb;
    cnt_b_n  = cnt_b;
    take_b   = 1'b0;
    done_b   = 1'b0;
    conflict = 1'b0;
    unique case (sb)
      IDLE: begin
        if (read_b && write) begin
          conflict = 1'b1;
        end else if (read_b || write) begin
          take_b = 1'b1;
          if (LAT_B <= 1) begin
            sb_n   = RESP;
            done_b = 1'b1;
          end else begin
            sb_n    = WAIT;
            cnt_b_n = CW'(LAT_B - 1);
          end
        end
      end
      WAIT: begin
        cnt_b_n = cnt_b - 1'b1;
        if (cnt_b == CW'(1)) begin
          sb_n   = RESP;
          done_b = 1'b1;
        end
      end
      RESP:    sb_n = IDLE;
      default: sb_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa           <= IDLE;
      sb           <= IDLE;
      cnt_a        <= '0;
      cnt_b        <= '0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      ok_a_q       <= 1'b0;
      ok_b_q       <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rdata_a      <= '0;
      rdata_b      <= '0;
      err_conflict <= 1'b0;
      err_range    <= 1'b0;
    end else begin
      sa    <= sa_n;
      sb    <= sb_n;
      cnt_a <= cnt_a_n;
      cnt_b <= cnt_b_n;
      if (take_a) begin
        addr_a_q <= address_a;
        ok_a_q   <= ok_a_live;
      end
      if (take_b) begin
        addr_b_q <= address_b;
        ok_b_q   <= ok_b_live;
        we_q     <= write;
        wdata_q  <= wdata;
        wmask_q  <= wmask;
      end
      if (done_a)
        rdata_a <= eff_ok_a ? mem[eff_idx_a] : '0;
      if (done_b && !eff_we)
        rdata_b <= eff_ok_b ? mem[eff_idx_b] : '0;
      if (conflict)
        err_conflict <= 1'b1;
      if ((take_a && !ok_a_live) || (take_b && !ok_b_live))
        err_range <= 1'b1;
    end
  end

  // Array is never reset; a write in flight when rst rises is dropped.
  always_ff @(posedge clk) begin
    if (!rst && done_b && eff_we && eff_ok_b) begin
      for (int i = 0; i < NB; i++) begin
        if (eff_wmask[i])
          mem[eff_idx_b][8*i +: 8] <= eff_wdata[8*i +: 8];
      end
    end
  end

endmodule
